// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM among NUM_REQ requesters.
// One access per cycle; reads return on a per-requester rvalid strobe two cycles after grant.
module ram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic                             ram_we,
    output logic [DATA_WIDTH-1:0]            ram_wdata,
    input  logic [DATA_WIDTH-1:0]            ram_rdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]      ptr_q,       ptr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic                  ram_we_q,    ram_we_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  rd1_q,       rd1_d;
    logic [IDX_W-1:0]      idx1_q,      idx1_d;
    logic [NUM_REQ-1:0]    rvalid_q,    rvalid_d;
    logic [DATA_WIDTH-1:0] rhold_q,     rhold_d;
    logic                  busy_q,      busy_d;

    logic                  gnt_vld;
    logic [IDX_W-1:0]      gnt_idx;

    // Round-robin scan starting at ptr_q; first requester found wins.
    always_comb begin
        int unsigned cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_vld && req[IDX_W'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
        if (rst) begin
            gnt_vld = 1'b0;
        end
    end

    assign gnt = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Next-state for pointer, issue stage and return stage.
    always_comb begin
        ptr_d       = ptr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        rd1_d       = 1'b0;
        idx1_d      = idx1_q;
        rvalid_d    = '0;
        rhold_d     = rhold_q;

        if (gnt_vld) begin
            ptr_d       = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            ram_addr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata_d = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            ram_we_d    = req_we[gnt_idx];
            rd1_d       = ~req_we[gnt_idx];
            idx1_d      = gnt_idx;
        end

        // The RAM samples the address at the end of the issue cycle; its data shows up one cycle later.
        if (rd1_q) begin
            rvalid_d = NUM_REQ'(1) << idx1_q;
        end
        if (|rvalid_q) begin
            rhold_d = ram_rdata;
        end

        busy_d = ram_we_d | rd1_d | (|rvalid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd1_q       <= 1'b0;
            idx1_q      <= '0;
            rvalid_q    <= '0;
            rhold_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rd1_q       <= rd1_d;
            idx1_q      <= idx1_d;
            rvalid_q    <= rvalid_d;
            rhold_q     <= rhold_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign rvalid    = rvalid_q;
    assign busy      = busy_q;
    // RAM output is passed straight through on the strobe cycle and held afterwards.
    assign rdata     = (|rvalid_q) ? ram_rdata : rhold_q;

endmodule
